// File: rtl/cfg_write_arbiter.sv
// ---------------------------------------------------------------------------
// cfg_write_arbiter
//   Arbitrates writes into a small configuration register bank between two
//   requesters: port A (SPI peripheral write path) and port B (local
//   sequencer / test path). Each port has a valid/ready handshake and a
//   one-deep holding register. A round-robin grant commits at most one
//   write per clock. The bank contents drive data0..data4.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   a_valid/a_addr/a_data   port A write request
//   a_ready                 port A holding register empty
//   b_valid/b_addr/b_data   port B write request
//   b_ready                 port B holding register empty
//   lock                    when 1, no commits; pending writes are held
//   data0..data4            bank registers 0..4
//   err_addr                one-cycle pulse after an out-of-range write is discarded
//   last_src                source of the most recent commit (0=A, 1=B)
// ---------------------------------------------------------------------------
module cfg_write_arbiter #(
  parameter int                 NUM_REGS  = 5,
  parameter int                 ADDR_W    = 7,
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              lock,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4,
  output logic              err_addr,
  output logic              last_src
);

  // One extra bit so NUM_REGS itself is representable for the unsigned compare.
  localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

  // Priority encoding: 0 = port A preferred, 1 = port B preferred.
  localparam logic PRI_A = 1'b0;
  localparam logic PRI_B = 1'b1;

  logic              r_hold_a_full;
  logic [ADDR_W-1:0] r_hold_a_addr;
  logic [DATA_W-1:0] r_hold_a_data;
  logic              r_hold_b_full;
  logic [ADDR_W-1:0] r_hold_b_addr;
  logic [DATA_W-1:0] r_hold_b_data;
  logic              r_prio;
  logic              r_err;
  logic              r_last_src;
  logic [DATA_W-1:0] r_bank [NUM_REGS];

  logic              w_xfer_a;
  logic              w_xfer_b;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_commit;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic              w_in_range;

  // Ready comes straight from the holding-register flag, never from valid.
  assign a_ready  = !r_hold_a_full;
  assign b_ready  = !r_hold_b_full;
  assign w_xfer_a = a_valid && !r_hold_a_full;
  assign w_xfer_b = b_valid && !r_hold_b_full;

  // A lone full holder wins outright; when both are full, prio decides.
  assign w_grant_a = !lock && r_hold_a_full && (!r_hold_b_full || (r_prio == PRI_A));
  assign w_grant_b = !lock && r_hold_b_full && (!r_hold_a_full || (r_prio == PRI_B));
  assign w_commit  = w_grant_a || w_grant_b;

  assign w_win_addr = w_grant_b ? r_hold_b_addr : r_hold_a_addr;
  assign w_win_data = w_grant_b ? r_hold_b_data : r_hold_a_data;
  // Full-width unsigned compare: no aliasing of high addresses onto the bank.
  assign w_in_range = ({1'b0, w_win_addr} < LP_NUM_REGS);

  // Control state and bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_a_full <= 1'b0;
      r_hold_b_full <= 1'b0;
      r_prio        <= PRI_A;
      r_err         <= 1'b0;
      r_last_src    <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_bank[k] <= RESET_VAL;
      end
    end else begin
      // A grant and a new transfer cannot coincide on one port: ready is low while full.
      if (w_grant_a)     r_hold_a_full <= 1'b0;
      else if (w_xfer_a) r_hold_a_full <= 1'b1;

      if (w_grant_b)     r_hold_b_full <= 1'b0;
      else if (w_xfer_b) r_hold_b_full <= 1'b1;

      // A discarded out-of-range write still consumes the grant and rotates prio.
      r_err <= w_commit && !w_in_range;

      if (w_commit) begin
        r_prio     <= w_grant_a ? PRI_B : PRI_A;
        r_last_src <= w_grant_b;
      end

      if (w_commit && w_in_range) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (w_win_addr == ADDR_W'(k)) r_bank[k] <= w_win_data;
        end
      end
    end
  end

  // Holding-register payload; qualified by the full flags, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_xfer_a) begin
      r_hold_a_addr <= a_addr;
      r_hold_a_data <= a_data;
    end
    if (w_xfer_b) begin
      r_hold_b_addr <= b_addr;
      r_hold_b_data <= b_data;
    end
  end

  assign data0    = r_bank[0];
  assign data1    = r_bank[1];
  assign data2    = r_bank[2];
  assign data3    = r_bank[3];
  assign data4    = r_bank[4];
  assign err_addr = r_err;
  assign last_src = r_last_src;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cfg_write_arbiter
//   Directed bench for cfg_write_arbiter: reset, single write, contention in
//   both priority orders, out-of-range discard, lock, and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_cfg_write_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              lock;
  logic [DATA_W-1:0] data0, data1, data2, data3, data4;
  logic              err_addr;
  logic              last_src;

  int n_cmp;
  int n_bad;

  cfg_write_arbiter #(
    .NUM_REGS  (5),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RESET_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .lock     (lock),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .data3    (data3),
    .data4    (data4),
    .err_addr (err_addr),
    .last_src (last_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bank(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    chk({tag, ".d0"}, data0, e0);
    chk({tag, ".d1"}, data1, e1);
    chk({tag, ".d2"}, data2, e2);
    chk({tag, ".d3"}, data3, e3);
    chk({tag, ".d4"}, data4, e4);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    lock    = 1'b0;

    // T1: reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      a_valid = i[0]; a_addr = 7'(i); a_data = 8'(8'h5A + i);
      b_valid = ~i[0]; b_addr = 7'(i + 1); b_data = 8'(8'hC3 ^ i);
      step();
    end
    chk_bank("t1_bank", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t1_a_ready", a_ready, 1);
    chk("t1_b_ready", b_ready, 1);
    chk("t1_err", err_addr, 0);
    chk("t1_last_src", last_src, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("t1_post_a_ready", a_ready, 1);

    // T2: single A write addr2=A5 (prio A -> B)
    a_valid = 1'b1; a_addr = 7'd2; a_data = 8'hA5;
    step();                                   // edge N: transfer
    a_valid = 1'b0;
    chk("t2_a_ready_low", a_ready, 0);
    chk("t2_d2_before", data2, 8'h00);
    step();                                   // edge N+1: commit
    chk("t2_d2_after", data2, 8'hA5);
    chk("t2_a_ready_back", a_ready, 1);
    chk("t2_last_src", last_src, 0);

    // T4: B out-of-range addr5 (prio B -> A)
    b_valid = 1'b1; b_addr = 7'd5; b_data = 8'hFF;
    step();
    b_valid = 1'b0;
    chk("t4_b_ready_low", b_ready, 0);
    chk("t4_err_pre", err_addr, 0);
    step();                                   // discard commit
    chk("t4_err_pulse", err_addr, 1);
    chk("t4_b_ready_back", b_ready, 1);
    chk("t4_last_src", last_src, 1);
    chk_bank("t4_bank", 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00);
    step();
    chk("t4_err_clear", err_addr, 0);

    // T3a: contention on addr1, prio A -> A first, B second
    a_valid = 1'b1; a_addr = 7'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 7'd1; b_data = 8'h22;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3a_a_ready_low", a_ready, 0);
    chk("t3a_b_ready_low", b_ready, 0);
    step();
    chk("t3a_d1_first", data1, 8'h11);
    chk("t3a_last_src1", last_src, 0);
    chk("t3a_a_ready", a_ready, 1);
    chk("t3a_b_held", b_ready, 0);
    step();
    chk("t3a_d1_final", data1, 8'h22);
    chk("t3a_last_src2", last_src, 1);
    chk("t3a_b_ready", b_ready, 1);

    // Top in-range address, also rotates prio to B
    a_valid = 1'b1; a_addr = 7'd4; a_data = 8'h44;
    step();
    a_valid = 1'b0;
    step();
    chk("t3m_d4", data4, 8'h44);
    chk("t3m_err", err_addr, 0);

    // T3b: same contention, prio B -> B first, A second
    a_valid = 1'b1; a_addr = 7'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 7'd1; b_data = 8'h22;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("t3b_last_src1", last_src, 1);
    chk("t3b_b_ready", b_ready, 1);
    chk("t3b_a_held", a_ready, 0);
    chk("t3b_d1_first", data1, 8'h22);
    step();
    chk("t3b_d1_final", data1, 8'h11);
    chk("t3b_last_src2", last_src, 0);

    // T4b: A addr 127 also out of range, no aliasing onto the bank
    a_valid = 1'b1; a_addr = 7'h7F; a_data = 8'hEE;
    step();
    a_valid = 1'b0;
    step();
    chk("t4b_err", err_addr, 1);
    chk_bank("t4b_bank", 8'h00, 8'h11, 8'hA5, 8'h00, 8'h44);

    // T5: lock holds a pending write
    lock = 1'b1;
    a_valid = 1'b1; a_addr = 7'd0; a_data = 8'h3C;
    step();
    a_valid = 1'b0;
    chk("t5_a_ready_low", a_ready, 0);
    step();
    step();
    chk("t5_a_still_low", a_ready, 0);
    chk("t5_d0_held", data0, 8'h00);
    lock = 1'b0;
    step();
    chk("t5_d0_commit", data0, 8'h3C);
    chk("t5_a_ready_back", a_ready, 1);

    // T6: reset before commit loses the write
    a_valid = 1'b1; a_addr = 7'd3; a_data = 8'h77;
    lock = 1'b1;
    step();
    a_valid = 1'b0;
    chk("t6_a_ready_low", a_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_a_ready_rst", a_ready, 1);
    chk_bank("t6_bank_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    lock = 1'b0;
    #2 rst_n = 1'b1;
    step();
    step();
    chk("t6_d3_lost", data3, 8'h00);
    chk("t6_a_ready_after", a_ready, 1);
    chk("t6_last_src", last_src, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
